nand2_unit: RTL and testbench

- Bitwise two-operand NAND block: c = ~(a & b), computed per bit.
- Provides an immediate combinational result plus a registered, valid-qualified copy for clocked consumers.
- Leaf primitive in the basic-logic library. The default WIDTH=1 gives the classic 2-input NAND truth table.

---
 rtl/nand_pkg.sv | 14 +
 rtl/nand_bit_cell.sv | 11 +
 rtl/nand2_unit.sv | 50 +++++
 tb/tb_nand2_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// Shared constants and helpers for the basic-logic NAND primitives.
package nand_pkg;

    // Widest operand any NAND primitive in the library is expected to handle.
    localparam int NAND_MAX_WIDTH = 64;

    // Value c_q takes on reset: the NAND of all-zero operands, i.e. all ones.
    // The result is right-aligned in a NAND_MAX_WIDTH-bit word, so the caller
    // slices off the low `width` bits.
    function automatic logic [NAND_MAX_WIDTH-1:0] c_q_reset_value(input int width);
        return {NAND_MAX_WIDTH{1'b1}} >> (NAND_MAX_WIDTH - width);
    endfunction

endpackage : nand_pkg

// File: rtl/nand_bit_cell.sv
// Single-bit 2-input NAND cell, the leaf of the vector NAND unit.
module nand_bit_cell (
    input  logic a,
    input  logic b,
    output logic c
);

    // Plain continuous assignment keeps X/Z behaviour identical to the & and ~ operators.
    assign c = ~(a & b);

endmodule : nand_bit_cell

// File: rtl/nand2_unit.sv
// Bitwise NAND with a zero-latency combinational result and a registered,
// valid-qualified copy (plus an all-zero flag) for clocked consumers.
// WIDTH is intended to stay within 1..NAND_MAX_WIDTH.
module nand2_unit
    import nand_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid,
    output logic             all_zero_q
);

    localparam logic [NAND_MAX_WIDTH-1:0] C_Q_RST_FULL = c_q_reset_value(WIDTH);
    localparam logic [WIDTH-1:0]          C_Q_RST      = C_Q_RST_FULL[WIDTH-1:0];

    // One NAND cell per bit forms the combinational result.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand_bit_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .c (c[i])
        );
    end

    // Capture the result on valid inputs; out_valid marks a fresh capture,
    // while c_q and all_zero_q hold across idle cycles. Reset wins over in_valid.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values,
        // keeping c_q and all_zero_q consistent with each other regardless of statement order.
        if (rst) begin
            c_q        <= C_Q_RST;
            out_valid  <= 1'b0;
            all_zero_q <= 1'b0;
        end else if (in_valid) begin
            c_q        <= c;
            out_valid  <= 1'b1;
            all_zero_q <= (c == '0);
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule : nand2_unit

// File: tb/tb_nand2_unit.sv
// Self-checking bench for nand2_unit: a WIDTH=1 and a WIDTH=8 instance share
// clock and reset; directed scenarios plus a randomized run against a
// truth-table reference model.
module tb_nand2_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, v1;
    logic [7:0] a8, b8;
    logic       v8;
    logic       c1, cq1, ov1, az1;
    logic [7:0] c8, cq8;
    logic       ov8, az8;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state (what the registered outputs should hold).
    logic       m1_cq, m1_ov, m1_az;
    logic [7:0] m8_cq;
    logic       m8_ov, m8_az;

    always #5 clk = ~clk;

    nand2_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .c(c1), .c_q(cq1), .out_valid(ov1), .all_zero_q(az1)
    );

    nand2_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .c(c8), .c_q(cq8), .out_valid(ov8), .all_zero_q(az8)
    );

    // Truth table of a 2-input NAND, indexed by {a,b}.
    function automatic logic nand_tt(input logic x, input logic y);
        logic [3:0] tt;
        tt = 4'b0111;
        return tt[{x, y}];
    endfunction

    function automatic logic [7:0] nand_vec8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = nand_tt(x[i], y[i]);
        return r;
    endfunction

    // Apply new inputs on the falling edge, then let combinational logic settle.
    task automatic drive(input logic r, input logic na1, input logic nb1, input logic nv1,
                         input logic [7:0] na8, input logic [7:0] nb8, input logic nv8);
        @(negedge clk);
        rst = r; a1 = na1; b1 = nb1; v1 = nv1; a8 = na8; b8 = nb8; v8 = nv8;
        #1;
    endtask

    // Advance one rising edge, updating the reference model from the sampled inputs.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m1_cq = 1'b1;   m1_ov = 1'b0; m1_az = 1'b0;
            m8_cq = 8'hFF;  m8_ov = 1'b0; m8_az = 1'b0;
        end else begin
            if (v1) begin
                m1_cq = nand_tt(a1, b1); m1_ov = 1'b1; m1_az = (m1_cq == 1'b0);
            end else begin
                m1_ov = 1'b0;
            end
            if (v8) begin
                m8_cq = nand_vec8(a8, b8); m8_ov = 1'b1; m8_az = (m8_cq == 8'h00);
            end else begin
                m8_ov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tests_run++;
        if (c1 !== 1'b0) begin
            tests_failed++; $display("FAIL reset_comb_c1: got %b want 0", c1);
        end
        step();
        step();
        tests_run++;
        if ({cq1, ov1, az1} !== 3'b100) begin
            tests_failed++; $display("FAIL reset_regs_w1: got {c_q,ov,az}=%b want 100", {cq1, ov1, az1});
        end
        tests_run++;
        if ({cq8, ov8, az8} !== {8'hFF, 2'b00}) begin
            tests_failed++; $display("FAIL reset_regs_w8: got c_q=%h ov=%b az=%b want FF 0 0", cq8, ov8, az8);
        end
        tests_run++;
        if (c1 !== 1'b0 || c8 !== 8'h00) begin
            tests_failed++; $display("FAIL reset_comb_hold: got c1=%b c8=%h want 0 00", c1, c8);
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] want_c;
        want_c = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[1], i[0], 1'b1, 8'h00, 8'h00, 1'b0);
            tests_run++;
            if (c1 !== want_c[i]) begin
                tests_failed++; $display("FAIL tt_comb_%0d: got %b want %b", i, c1, want_c[i]);
            end
            step();
            tests_run++;
            if ({cq1, ov1, az1} !== {want_c[i], 1'b1, (i == 3)}) begin
                tests_failed++;
                $display("FAIL tt_reg_%0d: got {c_q,ov,az}=%b want %b", i, {cq1, ov1, az1},
                         {want_c[i], 1'b1, (i == 3)});
            end
        end
    endtask

    task automatic test_x_prop();
        drive(1'b0, 1'b0, 1'bx, 1'b0, 8'h00, 8'h00, 1'b0);
        tests_run++;
        if (c1 !== 1'b1) begin
            tests_failed++; $display("FAIL x_prop: got %b want 1", c1);
        end
        step();
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tests_run++;
        if (c1 !== 1'b1) begin
            tests_failed++; $display("FAIL hold_comb: got %b want 1", c1);
        end
        step();
        tests_run++;
        if ({cq1, ov1, az1} !== 3'b001) begin
            tests_failed++; $display("FAIL hold_regs: got {c_q,ov,az}=%b want 001", {cq1, ov1, az1});
        end
    endtask

    task automatic test_vector8();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 8'hCC, 1'b1);
        tests_run++;
        if (c8 !== 8'h3F) begin
            tests_failed++; $display("FAIL vec8_comb: got %h want 3F", c8);
        end
        step();
        tests_run++;
        if ({cq8, ov8, az8} !== {8'h3F, 2'b10}) begin
            tests_failed++; $display("FAIL vec8_reg: got c_q=%h ov=%b az=%b want 3F 1 0", cq8, ov8, az8);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
        step();
        tests_run++;
        if ({cq8, ov8, az8} !== {8'h00, 2'b11}) begin
            tests_failed++; $display("FAIL vec8_allzero: got c_q=%h ov=%b az=%b want 00 1 1", cq8, ov8, az8);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want_c;
        want_c = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[1], i[0], 1'b1, 8'h00, 8'h00, 1'b0);
            step();
            tests_run++;
            if ({cq1, ov1} !== {want_c[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got {c_q,ov}=%b want %b", i, {cq1, ov1}, {want_c[i], 1'b1});
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [3:0] want_c;
        want_c = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive((i == 2), i[1], i[0], 1'b1, 8'h00, 8'h00, 1'b0);
            step();
            tests_run++;
            if (i == 2) begin
                if ({cq1, ov1, az1} !== 3'b100) begin
                    tests_failed++; $display("FAIL midrst_%0d: got {c_q,ov,az}=%b want 100", i, {cq1, ov1, az1});
                end
            end else if ({cq1, ov1, az1} !== {want_c[i], 1'b1, (i == 3)}) begin
                tests_failed++;
                $display("FAIL midrst_%0d: got {c_q,ov,az}=%b want %b", i, {cq1, ov1, az1},
                         {want_c[i], 1'b1, (i == 3)});
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom));
            tests_run++;
            if (c1 !== nand_tt(a1, b1) || c8 !== nand_vec8(a8, b8)) begin
                tests_failed++;
                $display("FAIL rand_comb_%0d: got c1=%b c8=%h want %b %h", n, c1, c8,
                         nand_tt(a1, b1), nand_vec8(a8, b8));
            end
            step();
            tests_run++;
            if ({cq1, ov1, az1} !== {m1_cq, m1_ov, m1_az} ||
                {cq8, ov8, az8} !== {m8_cq, m8_ov, m8_az}) begin
                tests_failed++;
                $display("FAIL rand_reg_%0d: got w1=%b w8=%h/%b%b want w1=%b w8=%h/%b%b", n,
                         {cq1, ov1, az1}, cq8, ov8, az8, {m1_cq, m1_ov, m1_az}, m8_cq, m8_ov, m8_az);
            end
        end
    endtask

    initial begin
        rst = 1'b1; a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;
        m1_cq = 1'b1; m1_ov = 1'b0; m1_az = 1'b0;
        m8_cq = 8'hFF; m8_ov = 1'b0; m8_az = 1'b0;
        test_reset();
        test_truth_table();
        test_x_prop();
        test_hold();
        test_vector8();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_nand2_unit
